// File: rtl/fifo_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester-side handshake and the FIFO write-port signals that
// the round-robin write arbiter sits between.
//   req        : per-requester write request, held with data until acked
//   req_data   : packed requester data, requester i in [i*MEMORY_WIDTH +: MEMORY_WIDTH]
//   w_full     : FIFO full flag
//   gnt        : registered one-hot grant (zero when idle)
//   ack        : word accepted from requester i this cycle
//   fifo_w_en  : FIFO write enable
//   fifo_wdata : FIFO write data
// Modports: slave = arbiter view, master = requesters/FIFO environment view.
// ----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int MEMORY_WIDTH = 4
);
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*MEMORY_WIDTH-1:0] req_data;
  logic                            w_full;
  logic [NUM_REQ-1:0]              gnt;
  logic [NUM_REQ-1:0]              ack;
  logic                            fifo_w_en;
  logic [MEMORY_WIDTH-1:0]         fifo_wdata;

  modport slave (
    input  req, req_data, w_full,
    output gnt, ack, fifo_w_en, fifo_wdata
  );

  modport master (
    output req, req_data, w_full,
    input  gnt, ack, fifo_w_en, fifo_wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
// Burst-based round-robin arbiter sharing the async FIFO write port among
// NUM_REQ requesters. Lives entirely in the write clock domain.
// An owner keeps the port for up to BURST_LEN accepted words, or until it
// withdraws its request; the grant then rotates with no idle bubble.
// Ports:
//   w_clk  : write-domain clock, all logic on posedge
//   wrst_n : asynchronous active-low reset
//   bus    : fifo_wr_arbiter_if.slave (req/req_data/w_full in,
//            gnt/ack/fifo_w_en/fifo_wdata out)
// ----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MEMORY_WIDTH = 4,
  parameter int BURST_LEN    = 4
) (
  input  logic                 w_clk,
  input  logic                 wrst_n,
  fifo_wr_arbiter_if.slave     bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             state_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic [CNT_W-1:0]   count_r;
  logic [IDX_W-1:0]   last_r;

  logic [IDX_W-1:0]   owner_s;
  logic               owner_req_s;
  logic               accept_s;
  logic               last_word_s;
  logic               release_s;
  logic [IDX_W-1:0]   base_s;
  logic [NUM_REQ-1:0] pick_s;

  // Index of the set bit in a one-hot vector (0 when the vector is zero).
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Round-robin pick: search upward from base+1 with wrap, base itself last.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [IDX_W-1:0] base,
                                                 input logic [NUM_REQ-1:0] req);
    logic [NUM_REQ-1:0] pick;
    logic               found;
    int                 idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(base) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // Owner decode, accept/release decisions and next-owner selection.
  always_comb begin
    owner_s     = onehot_idx(gnt_r);
    owner_req_s = bus.req[owner_s];
    accept_s    = (state_r == ST_GRANT) && owner_req_s && !bus.w_full;
    last_word_s = (count_r == CNT_W'(BURST_LEN - 1));
    // Release on a completed burst or when the owner withdraws (even while full).
    release_s   = (state_r == ST_GRANT) && (!owner_req_s || (accept_s && last_word_s));
    // On release the outgoing owner becomes the lowest priority immediately.
    if (release_s) begin
      base_s = owner_s;
    end else begin
      base_s = last_r;
    end
    pick_s = rr_pick(base_s, bus.req);
  end

  // Write-port drive: only the current owner's word, only when accepted.
  always_comb begin
    bus.fifo_w_en = accept_s;
    bus.ack       = '0;
    if (accept_s) begin
      bus.ack[owner_s] = 1'b1;
    end else begin
      bus.ack = '0;
    end
    if (state_r == ST_GRANT) begin
      bus.fifo_wdata = bus.req_data[int'(owner_s)*MEMORY_WIDTH +: MEMORY_WIDTH];
    end else begin
      bus.fifo_wdata = '0;
    end
  end

  assign bus.gnt = gnt_r;

  // Grant FSM: burst counting, rotation and back-to-back re-arbitration.
  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_r <= ST_IDLE;
      gnt_r   <= '0;
      count_r <= '0;
      last_r  <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|bus.req) begin
            gnt_r   <= pick_s;
            state_r <= ST_GRANT;
            count_r <= '0;
          end else begin
            gnt_r   <= '0;
          end
        end
        ST_GRANT: begin
          if (release_s) begin
            last_r  <= owner_s;
            count_r <= '0;
            if (|bus.req) begin
              gnt_r <= pick_s;
            end else begin
              gnt_r   <= '0;
              state_r <= ST_IDLE;
            end
          end else if (accept_s) begin
            count_r <= count_r + CNT_W'(1);
          end else begin
            count_r <= count_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          gnt_r   <= '0;
          count_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed vectors for the burst round-robin FIFO write arbiter
// (NUM_REQ=4, MEMORY_WIDTH=4, BURST_LEN=4), plus a randomized phase with a
// per-requester in-order scoreboard. A negedge monitor checks the port-level
// invariants every cycle.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  logic w_clk;
  logic wrst_n;
  int   n_vec;
  int   n_err;
  logic mon_en;
  logic sb_en;
  int   ack_cnt [4];
  logic [3:0] last_ack;
  logic [3:0] exp_seq [4];
  logic [3:0] seq [4];

  fifo_wr_arbiter_if #(.NUM_REQ(4), .MEMORY_WIDTH(4)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(4), .MEMORY_WIDTH(4), .BURST_LEN(4)) dut (
    .w_clk  (w_clk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge w_clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [3:0] v);
    bus.req_data[i*4 +: 4] = v;
  endtask

  task automatic do_reset;
    wrst_n       = 1'b0;
    bus.req      = 4'b0000;
    bus.w_full   = 1'b0;
    bus.req_data = 16'h0000;
    tick;
    tick;
    wrst_n = 1'b1;
  endtask

  // Per-cycle invariant checks, ack accounting and the in-order scoreboard.
  always @(negedge w_clk) begin
    if (mon_en) begin
      int o;
      o = 0;
      for (int i = 0; i < 4; i++) if (bus.gnt[i]) o = i;
      chk("inv_onehot", 32'($onehot0(bus.gnt)), 32'd1);
      chk("inv_full", 32'(bus.fifo_w_en & bus.w_full), 32'd0);
      chk("en_model", 32'(bus.fifo_w_en), 32'((|(bus.gnt & bus.req)) & !bus.w_full));
      chk("ack_model", 32'(bus.ack), bus.fifo_w_en ? 32'(bus.gnt) : 32'd0);
      chk("wdata_model", 32'(bus.fifo_wdata),
          (|bus.gnt) ? 32'(bus.req_data[o*4 +: 4]) : 32'd0);
      for (int i = 0; i < 4; i++) if (bus.ack[i]) ack_cnt[i]++;
      last_ack = bus.ack;
      if (sb_en && bus.fifo_w_en) begin
        chk("sb_order", 32'(bus.fifo_wdata), 32'(exp_seq[o]));
        exp_seq[o] = exp_seq[o] + 4'd1;
      end
    end
  end

  initial begin
    int base;
    logic [3:0] r;
    n_vec  = 0;
    n_err  = 0;
    mon_en = 1'b0;
    sb_en  = 1'b0;
    last_ack = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      ack_cnt[i] = 0;
      exp_seq[i] = 4'd0;
      seq[i]     = 4'd0;
    end
    wrst_n       = 1'b0;
    bus.req      = 4'b0000;
    bus.w_full   = 1'b0;
    bus.req_data = 16'h0000;
    tick;
    mon_en = 1'b1;
    tick;
    @(negedge w_clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_en", 32'(bus.fifo_w_en), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_wdata", 32'(bus.fifo_wdata), 32'd0);
    tick;
    wrst_n = 1'b1;

    // 1: sole requester 1, data A, keeps the port across burst boundary
    bus.req = 4'b0010;
    set_data(1, 4'hA);
    @(negedge w_clk);
    chk("t1_idle_gnt", 32'(bus.gnt), 32'd0);
    tick;
    for (int k = 0; k < 4; k++) begin
      @(negedge w_clk);
      chk("t1_gnt", 32'(bus.gnt), 32'h2);
      chk("t1_en", 32'(bus.fifo_w_en), 32'd1);
      chk("t1_wdata", 32'(bus.fifo_wdata), 32'hA);
      tick;
    end
    @(negedge w_clk);
    chk("t1_regrant", 32'(bus.gnt), 32'h2);
    tick;
    bus.req = 4'b0000;
    @(negedge w_clk);
    chk("t1_wd_en", 32'(bus.fifo_w_en), 32'd0);
    tick;
    @(negedge w_clk);
    chk("t1_idle_again", 32'(bus.gnt), 32'd0);
    tick;

    // 2: all request, bursts rotate 0,1,2,3,0 with no bubble; 3: full mid-burst of 2
    do_reset;
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 4'(i + 1));
    @(negedge w_clk);
    chk("t2_idle_gnt", 32'(bus.gnt), 32'd0);
    tick;
    for (int k = 0; k < 26; k++) begin
      int o;
      o = (k / 4) % 4;
      @(negedge w_clk);
      chk("t2_gnt", 32'(bus.gnt), 32'(1 << o));
      chk("t2_en", 32'(bus.fifo_w_en), 32'd1);
      chk("t2_wdata", 32'(bus.fifo_wdata), 32'(o + 1));
      tick;
    end
    bus.w_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge w_clk);
      chk("t3_full_en", 32'(bus.fifo_w_en), 32'd0);
      chk("t3_full_ack", 32'(bus.ack), 32'd0);
      chk("t3_full_gnt", 32'(bus.gnt), 32'h4);
      tick;
    end
    bus.w_full = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge w_clk);
      chk("t3_resume_gnt", 32'(bus.gnt), 32'h4);
      chk("t3_resume_ack", 32'(bus.ack), 32'h4);
      tick;
    end
    @(negedge w_clk);
    chk("t3_rotate", 32'(bus.gnt), 32'h8);
    tick;

    // 4: owner 1 withdraws after one word, requester 3 takes over
    do_reset;
    bus.req = 4'b1010;
    set_data(1, 4'h5);
    set_data(3, 4'h9);
    @(negedge w_clk);
    chk("t4_idle_gnt", 32'(bus.gnt), 32'd0);
    tick;
    base = ack_cnt[1];
    @(negedge w_clk);
    chk("t4_first_ack", 32'(bus.ack), 32'h2);
    tick;
    bus.req = 4'b1000;
    @(negedge w_clk);
    chk("t4_wd_ack", 32'(bus.ack), 32'd0);
    tick;
    @(negedge w_clk);
    chk("t4_gnt3", 32'(bus.gnt), 32'h8);
    chk("t4_ack1_count", 32'(ack_cnt[1] - base), 32'd1);
    tick;

    // 5: asynchronous reset mid-burst of owner 3
    do_reset;
    bus.req = 4'b1000;
    tick;
    for (int k = 0; k < 2; k++) begin
      @(negedge w_clk);
      chk("t5_burst_ack", 32'(bus.ack), 32'h8);
      tick;
    end
    #2;
    wrst_n = 1'b0;
    #1;
    chk("t5_async_gnt", 32'(bus.gnt), 32'd0);
    chk("t5_async_en", 32'(bus.fifo_w_en), 32'd0);
    tick;
    tick;
    bus.req = 4'b1001;
    wrst_n  = 1'b1;
    @(negedge w_clk);
    chk("t5_post_en", 32'(bus.fifo_w_en), 32'd0);
    tick;
    @(negedge w_clk);
    chk("t5_first_gnt", 32'(bus.gnt), 32'h1);
    tick;

    // 6: random requests and full flag, scoreboard checks per-requester order
    do_reset;
    for (int i = 0; i < 4; i++) set_data(i, 4'd0);
    last_ack = 4'b0000;
    sb_en = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      r = bus.req;
      for (int i = 0; i < 4; i++) begin
        if (last_ack[i]) seq[i] = seq[i] + 4'd1;
        if (r[i]) begin
          if (last_ack[i] || ($urandom_range(0, 15) == 0)) r[i] = ($urandom_range(0, 3) != 0);
        end else begin
          r[i] = ($urandom_range(0, 2) == 0);
        end
        set_data(i, seq[i]);
      end
      bus.req    = r;
      bus.w_full = ($urandom_range(0, 3) == 0);
      tick;
    end
    sb_en      = 1'b0;
    bus.req    = 4'b0000;
    bus.w_full = 1'b0;
    tick;
    tick;
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
